// File: rtl/axis_fifo_fwft.sv
// axis_fifo_fwft: AXI4-Stream first-word-fall-through FIFO.
//  Stores {tlast,tdata} in a DEPTH-entry RAM. The pointers carry an extra wrap
//  bit, so all DEPTH entries are usable. The head word is presented on m_axis
//  without a read strobe. Fill level and almost-full/almost-empty flags are
//  also provided.
// Ports:
//  clk, rst_n          clock (rising edge), asynchronous active-low reset
//  s_axis_t*           write side: tdata, tlast, tvalid in; tready out (= !full)
//  m_axis_t*           read side: tdata, tlast, tvalid out (= !empty); tready in
//  level               stored word count, 0..DEPTH
//  almost_full         level >= AFULL_THRESH
//  almost_empty        level <= AEMPTY_THRESH
module axis_fifo_fwft #(
   parameter int unsigned DEPTH         = 8,
   parameter int unsigned DWIDTH        = 16,
   parameter int unsigned AFULL_THRESH  = 6,
   parameter int unsigned AEMPTY_THRESH = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [DWIDTH-1:0]         s_axis_tdata,
   input  logic                      s_axis_tlast,
   input  logic                      s_axis_tvalid,
   output logic                      s_axis_tready,
   output logic [DWIDTH-1:0]         m_axis_tdata,
   output logic                      m_axis_tlast,
   output logic                      m_axis_tvalid,
   input  logic                      m_axis_tready,
   output logic [$clog2(DEPTH):0]    level,
   output logic                      almost_full,
   output logic                      almost_empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;
   localparam logic [PW-1:0] AFULL_LVL  = PW'(AFULL_THRESH);
   localparam logic [PW-1:0] AEMPTY_LVL = PW'(AEMPTY_THRESH);

   logic [DWIDTH:0] mem [DEPTH];

   logic [PW-1:0] wptr;
   logic [PW-1:0] rptr;
   logic [PW-1:0] wptr_nxt;
   logic [PW-1:0] rptr_nxt;
   logic [PW-1:0] level_nxt;
   logic          full_q;
   logic          empty_q;
   logic          full_nxt;
   logic          empty_nxt;
   logic          push;
   logic          pop;

   // The handshake sides see only registered flags, never the opposite side's valid/ready.
   assign s_axis_tready = !full_q;
   assign m_axis_tvalid = !empty_q;

   // Head word falls through from the RAM at the read index.
   assign {m_axis_tlast, m_axis_tdata} = mem[rptr[AW-1:0]];

   // Next pointers and the flags derived from them.
   // The flags are registered on the same edge as the pointers they describe.
   always_comb begin
      push      = s_axis_tvalid && !full_q;
      pop       = m_axis_tready && !empty_q;
      wptr_nxt  = wptr + PW'(push);
      rptr_nxt  = rptr + PW'(pop);
      level_nxt = wptr_nxt - rptr_nxt;
      empty_nxt = (wptr_nxt == rptr_nxt);
      full_nxt  = (wptr_nxt[AW-1:0] == rptr_nxt[AW-1:0]) &&
                  (wptr_nxt[AW] != rptr_nxt[AW]);
   end

   // Pointer and status registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr         <= '0;
         rptr         <= '0;
         level        <= '0;
         empty_q      <= 1'b1;
         full_q       <= 1'b0;
         almost_full  <= (AFULL_LVL == '0);
         almost_empty <= 1'b1;
      end else begin
         wptr         <= wptr_nxt;
         rptr         <= rptr_nxt;
         level        <= level_nxt;
         empty_q      <= empty_nxt;
         full_q       <= full_nxt;
         almost_full  <= (level_nxt >= AFULL_LVL);
         almost_empty <= (level_nxt <= AEMPTY_LVL);
      end
   end

   // Storage is not reset; stale contents are never visible because tvalid gates them.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wptr[AW-1:0]] <= {s_axis_tlast, s_axis_tdata};
      end
   end

endmodule
